// File: rtl/therm_dac_dwa_drv_pkg.sv
// therm_dac_dwa_drv shared definitions
// state encodings and default widths for the SAR thermometer DAC path
package therm_dac_dwa_drv_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SETTLE = 2;
  localparam int CNT_W      = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

endpackage

// File: rtl/therm_dac_dwa_drv_therm_rotate.sv
// therm_rotate: binary code to thermometer word,
// then left barrel rotate by the DWA pointer
module therm_rotate #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]        code_i,
  input  logic [WIDTH-1:0]        ptr_i,
  output logic [(1<<WIDTH)-1:0]   unit_o
);

  localparam int N = 1 << WIDTH;

  logic [N-1:0]   therm;
  logic [2*N-1:0] dbl;

  // k LSBs set, doubled so the upper half of the shift is a rotate
  always_comb begin
    therm = '0;
    for (int i = 0; i < N; i++) begin
      therm[i] = (WIDTH'(i) < code_i);
    end
    dbl    = {therm, therm} << ptr_i;
    unit_o = dbl[2*N-1:N];
  end

endmodule

// File: rtl/therm_dac_dwa_drv.sv
// therm_dac_dwa_drv: DWA thermometer element driver with
// valid/ready code intake and settle pulse
module therm_dac_dwa_drv
  import therm_dac_dwa_drv_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE,
  parameter int DWA_EN        = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic [WIDTH-1:0]        code_i,
  input  logic                    code_valid_i,
  output logic                    code_ready_o,
  output logic [(1<<WIDTH)-1:0]   unit_o,
  output logic                    settled_o,
  output logic [WIDTH-1:0]        ptr_o
);

  localparam int N = 1 << WIDTH;
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] ptr_q, ptr_nx;
  logic [N-1:0]     unit_q, unit_nx;
  logic             settled_q, settled_d;
  logic             accept;

  therm_rotate #(.WIDTH(WIDTH)) u_rot (
    .code_i (code_i),
    .ptr_i  (ptr_q),
    .unit_o (unit_nx)
  );

  assign ptr_nx       = (DWA_EN != 0) ? ptr_q + code_i : '0;
  assign code_ready_o = (state_q == ST_IDLE);
  assign unit_o       = unit_q;
  assign settled_o    = settled_q;
  assign ptr_o        = ptr_q;

  // next state, accept strobe and settle pulse; clear overrides all
  always_comb begin
    state_d   = state_q;
    settled_d = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (code_valid_i) begin
          accept  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d   = ST_IDLE;
          settled_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d   = ST_IDLE;
      settled_d = 1'b0;
      accept    = 1'b0;
    end
  end

  // state and settle pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settled_q <= settled_d;
    end
  end

  // settle down-counter, loaded on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= SETTLE_CNT;
    end else if (state_q == ST_SETTLE && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // element word and DWA pointer, held between conversions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_q <= '0;
      ptr_q  <= '0;
    end else if (clear_i) begin
      unit_q <= '0;
      ptr_q  <= '0;
    end else if (accept) begin
      unit_q <= unit_nx;
      ptr_q  <= ptr_nx;
    end
  end

endmodule
